// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution sample-RAM read path.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned DEF_N = 8;
  localparam int unsigned DEF_M = 6;
  localparam int unsigned DEF_K = 3;

  // Width of a tap index able to hold 0..k-1 (never narrower than one bit).
  function automatic int unsigned idx_width(input int unsigned k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

  // Number of windows for l samples and k taps; padding gives one window per sample.
  function automatic int unsigned win_count(input int unsigned l, input int unsigned k,
                                            input bit pad);
    if (pad)
      return l;
    else
      return (l >= k) ? (l - k + 1) : 0;
  endfunction

endpackage

// File: rtl/window_index_counter.sv
// Base/tap index pair for a K-tap sliding window, with first/last-tap and last-window flags.
module window_index_counter
  import conv_pkg::*;
#(
  parameter int unsigned K  = DEF_K,
  parameter int unsigned BW = DEF_M,
  parameter int unsigned JW = idx_width(K)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_adv,
  input  logic [BW:0]   i_win,
  output logic [BW-1:0] o_b,
  output logic [JW-1:0] o_j,
  output logic          o_first_tap,
  output logic          o_last_tap,
  output logic          o_last_win
);

  logic [BW-1:0] r_b;
  logic [JW-1:0] r_j;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_b <= '0;
      r_j <= '0;
    end else if (i_clr) begin
      r_b <= '0;
      r_j <= '0;
    end else if (i_adv) begin
      if (o_last_tap) begin
        r_j <= '0;
        r_b <= r_b + BW'(1);
      end else begin
        r_j <= r_j + JW'(1);
      end
    end
  end

  assign o_b         = r_b;
  assign o_j         = r_j;
  assign o_first_tap = (r_j == '0);
  assign o_last_tap  = (r_j == JW'(K - 1));
  assign o_last_win  = (((BW + 1)'(r_b) + (BW + 1)'(1)) == i_win);

endmodule

// File: rtl/ram_window_reader.sv
// Sliding-window read sequencer for the convolution sample RAM, streaming taps to the MAC.
// Optional build macro ZERO_PAD_EN: one window per sample, out-of-range taps read as zero.
module ram_window_reader
  import conv_pkg::*;
#(
  parameter int unsigned N = DEF_N,
  parameter int unsigned M = DEF_M,
  parameter int unsigned K = DEF_K
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M:0]   len,
  output logic         rd,
  output logic [M-1:0] adr,
  input  logic [N-1:0] ram_data,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_first_tap,
  output logic         out_last_tap,
  output logic         out_last,
  output logic         busy,
  output logic         done
);

  localparam int unsigned LW = M + 1;
  localparam int unsigned JW = idx_width(K);
`ifdef ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  state_t         r_state, w_state_nxt;
  logic [LW-1:0]  r_win, w_win_nxt, w_win_new;
  logic [M-1:0]   r_adr, w_adr_nxt, w_adr;
  logic [N-1:0]   r_out_data, w_data_nxt;
  logic           r_out_valid, w_valid_nxt;
  logic           r_first, w_first_nxt;
  logic           r_last_tap, w_last_tap_nxt;
  logic           r_last, w_last_nxt;
  logic           r_busy, w_busy_nxt;
  logic           r_done, w_done_nxt;
  logic           w_clr, w_fetch, w_rd;
  logic [M-1:0]   w_b;
  logic [JW-1:0]  w_j;
  logic           w_first_tap, w_last_tap, w_last_win;

  window_index_counter #(.K(K), .BW(M), .JW(JW)) u_idx (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_clr),
    .i_adv       (w_fetch),
    .i_win       (r_win),
    .o_b         (w_b),
    .o_j         (w_j),
    .o_first_tap (w_first_tap),
    .o_last_tap  (w_last_tap),
    .o_last_win  (w_last_win)
  );

  assign w_win_new = LW'(win_count(32'(len), K, PAD));
  assign w_adr     = w_b + M'(w_j);

`ifdef ZERO_PAD_EN
  // Taps past the end of the sample set are padded rather than read.
  logic [LW-1:0] r_len, w_len_nxt, w_sum;
  logic          w_in_range;
  assign w_sum      = LW'(w_b) + LW'(w_j);
  assign w_in_range = (w_sum < r_len);
`endif

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_win_nxt      = r_win;
    w_adr_nxt      = r_adr;
    w_data_nxt     = r_out_data;
    w_valid_nxt    = r_out_valid;
    w_first_nxt    = r_first;
    w_last_tap_nxt = r_last_tap;
    w_last_nxt     = r_last;
    w_clr          = 1'b0;
    w_fetch        = 1'b0;
    w_rd           = 1'b0;
`ifdef ZERO_PAD_EN
    w_len_nxt      = r_len;
`endif
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_win_nxt = w_win_new;
`ifdef ZERO_PAD_EN
          w_len_nxt = len;
`endif
          if (w_win_new == '0) begin
            w_state_nxt = DONE;
          end else begin
            w_clr       = 1'b1;
            w_state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (!r_out_valid || out_ready) begin
          w_fetch = 1'b1;
`ifdef ZERO_PAD_EN
          if (w_in_range) begin
            w_rd       = 1'b1;
            w_adr_nxt  = w_adr;
            w_data_nxt = ram_data;
          end else begin
            w_data_nxt = '0;
          end
`else
          w_rd       = 1'b1;
          w_adr_nxt  = w_adr;
          w_data_nxt = ram_data;
`endif
          w_valid_nxt    = 1'b1;
          w_first_nxt    = w_first_tap;
          w_last_tap_nxt = w_last_tap;
          w_last_nxt     = w_last_tap && w_last_win;
          if (w_last_tap && w_last_win)
            w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          w_valid_nxt    = 1'b0;
          w_first_nxt    = 1'b0;
          w_last_tap_nxt = 1'b0;
          w_last_nxt     = 1'b0;
          w_state_nxt    = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt == RUN) || (w_state_nxt == DRAIN);
    w_done_nxt = (w_state_nxt == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_win       <= '0;
      r_adr       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_first     <= 1'b0;
      r_last_tap  <= 1'b0;
      r_last      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef ZERO_PAD_EN
      r_len       <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_win       <= w_win_nxt;
      r_adr       <= w_adr_nxt;
      r_out_data  <= w_data_nxt;
      r_out_valid <= w_valid_nxt;
      r_first     <= w_first_nxt;
      r_last_tap  <= w_last_tap_nxt;
      r_last      <= w_last_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
`ifdef ZERO_PAD_EN
      r_len       <= w_len_nxt;
`endif
    end
  end

  // The RAM read port is combinational, so rd/adr are driven in the fetch cycle itself.
  assign rd            = w_rd;
  assign adr           = w_adr_nxt;
  assign out_data      = r_out_data;
  assign out_valid     = r_out_valid;
  assign out_first_tap = r_first;
  assign out_last_tap  = r_last_tap;
  assign out_last      = r_last;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_ram_window_reader.sv
// Scoreboard bench for ram_window_reader; ZERO_PAD_EN builds use K=2 and add the padding pass.
module tb_ram_window_reader;

  localparam int unsigned N = 8;
  localparam int unsigned M = 6;
`ifdef ZERO_PAD_EN
  localparam int unsigned K = 2;
  localparam bit PAD = 1'b1;
`else
  localparam int unsigned K = 3;
  localparam bit PAD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [M:0]   len = '0;
  logic         rd;
  logic [M-1:0] adr;
  logic [N-1:0] ram_data;
  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         out_first_tap, out_last_tap, out_last, busy, done;

  logic [N-1:0] mem [2**M];
  assign ram_data = rd ? mem[adr] : 'z;

  ram_window_reader #(.N(N), .M(M), .K(K)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .len           (len),
    .rd            (rd),
    .adr           (adr),
    .ram_data      (ram_data),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_first_tap (out_first_tap),
    .out_last_tap  (out_last_tap),
    .out_last      (out_last),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] d;
    logic         f;
    logic         lt;
    logic         l;
  } beat_t;

  beat_t exp_q[$];
  int total = 0, bad = 0;
  int cyc = 0, beats = 0, rd_cnt = 0, exp_rd = 0, done_cnt = 0, done_cyc = -1;
  int first_beat = -1, last_beat = -1, s_cyc = 0;
  int rdy_mode = 0, rdy_idx = 0;
  bit busy_seen = 0, act_seen = 0, stall_prev = 0;
  logic [N-1:0] held = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer ready: constant, or the repeating 1,0,0,1 pattern.
  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_mode == 0) begin
      out_ready = 1'b1;
    end else begin
      out_ready = ((rdy_idx % 4) == 0) || ((rdy_idx % 4) == 3);
      rdy_idx++;
    end
  end

  // Output monitor and scoreboard consumer.
  initial forever begin
    beat_t e;
    @(negedge clk);
    if (!rst) begin
      if (busy) busy_seen = 1;
      if (rd || out_valid) act_seen = 1;
      if (rd) rd_cnt++;
      if (stall_prev) check_eq("hold_data", 32'(out_data), 32'(held));
      if (out_valid && !out_ready) check_eq("rd_in_stall", 32'(rd), 0);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("data", 32'(out_data), 32'(e.d));
          check_eq("first_tap", 32'(out_first_tap), 32'(e.f));
          check_eq("last_tap", 32'(out_last_tap), 32'(e.lt));
          check_eq("last", 32'(out_last), 32'(e.l));
        end
        beats++;
        if (first_beat < 0) first_beat = cyc;
        last_beat = cyc;
      end
      stall_prev = out_valid && !out_ready;
      held = out_data;
    end else begin
      stall_prev = 0;
    end
  end

  task automatic clear_stats();
    beats = 0; rd_cnt = 0; exp_rd = 0; first_beat = -1; last_beat = -1;
    busy_seen = 0; act_seen = 0;
  endtask

  // Reference stream: every window base, every tap, padded past l when enabled.
  task automatic push_model(input int l);
    int w;
    beat_t e;
    w = PAD ? l : ((l >= int'(K)) ? (l - int'(K) + 1) : 0);
    for (int b = 0; b < w; b++) begin
      for (int j = 0; j < int'(K); j++) begin
        e.d  = (b + j < l) ? mem[b + j] : '0;
        e.f  = (j == 0);
        e.lt = (j == int'(K) - 1);
        e.l  = (j == int'(K) - 1) && (b == w - 1);
        if (b + j < l) exp_rd++;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic start_pass(input int l);
    @(posedge clk);
    #1;
    len = (M + 1)'(l);
    start = 1'b1;
    s_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string tag);
    int n = 0;
    while (done_cnt == d0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (n >= 400) check_eq({tag, "_timeout"}, 1, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_pass(input string tag);
    check_eq({tag, "_beats"}, 32'(beats), 32'(exp_rd == 0 && !PAD ? 0 : beats));
    check_eq({tag, "_q_empty"}, 32'(exp_q.size()), 0);
    check_eq({tag, "_rd_cnt"}, 32'(rd_cnt), 32'(exp_rd));
  endtask

  initial begin
    int d0, n;
    for (int i = 0; i < 2**M; i++) mem[i] = N'((i + 1) * 10);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rd", 32'(rd), 0);
    check_eq("rst_adr", 32'(adr), 0);
    check_eq("rst_data", 32'(out_data), 0);
    check_eq("rst_valid", 32'(out_valid), 0);
    check_eq("rst_flags", {29'd0, out_first_tap, out_last_tap, out_last}, 0);
    check_eq("rst_busy_done", {30'd0, busy, done}, 0);
    rst = 1'b0;

    // T1: constant ready, back-to-back beats.
    clear_stats(); rdy_mode = 0; d0 = done_cnt;
    push_model(5);
    check_eq("t1_model_len", 32'(exp_q.size()), PAD ? 32'(5 * K) : 32'(3 * K));
    start_pass(5);
    wait_done(d0, "t1");
    check_pass("t1");
    check_eq("t1_beat_count", 32'(beats), PAD ? 32'(5 * K) : 32'(3 * K));
    check_eq("t1_latency", 32'(first_beat - s_cyc), 2);
    check_eq("t1_back_to_back", 32'(last_beat - first_beat), 32'(beats - 1));
    check_eq("t1_done_after_last", 32'(done_cyc - last_beat), 1);
    check_eq("t1_done_count", 32'(done_cnt - d0), 1);
    check_eq("t1_busy_seen", 32'(busy_seen), 1);
    check_eq("t1_idle_busy", 32'(busy), 0);

    // T2: ready toggling 1,0,0,1.
    clear_stats(); rdy_mode = 1; rdy_idx = 0; d0 = done_cnt;
    push_model(5);
    start_pass(5);
    wait_done(d0, "t2");
    check_pass("t2");
    check_eq("t2_beat_count", 32'(beats), PAD ? 32'(5 * K) : 32'(3 * K));
    rdy_mode = 0;

    // T3: too few samples (empty pass when padding is enabled).
    clear_stats(); d0 = done_cnt;
    start_pass(PAD ? 0 : 2);
    wait_done(d0, "t3");
    n = done_cyc - s_cyc;
    check_eq("t3_done_latency", 32'(n >= 1 && n <= 2), 1);
    check_eq("t3_no_activity", 32'(act_seen), 0);
    check_eq("t3_no_busy", 32'(busy_seen), 0);
    check_eq("t3_done_count", 32'(done_cnt - d0), 1);

    // T4: a second start during the pass is ignored.
    clear_stats(); d0 = done_cnt;
    push_model(5);
    start_pass(5);
    repeat (2) @(posedge clk);
    #1;
    len = 7'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(d0, "t4");
    check_pass("t4");
    check_eq("t4_beat_count", 32'(beats), PAD ? 32'(5 * K) : 32'(3 * K));
    check_eq("t4_done_count", 32'(done_cnt - d0), 1);

    // T5: reset after the fourth beat, then a clean pass.
    clear_stats(); d0 = done_cnt;
    push_model(5);
    start_pass(5);
    n = 0;
    while (beats < 4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check_eq("t5_beat4_timeout", 1, 0);
    #1;
    rst = 1'b1;
    #1;
    check_eq("t5_rst_valid", 32'(out_valid), 0);
    check_eq("t5_rst_data", 32'(out_data), 0);
    check_eq("t5_rst_rd_adr", {25'd0, rd, adr}, 0);
    check_eq("t5_rst_flags", {27'd0, out_first_tap, out_last_tap, out_last, busy, done}, 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("t5_no_done", 32'(done_cnt - d0), 0);
    exp_q.delete();
    rst = 1'b0;
    clear_stats(); d0 = done_cnt;
    push_model(5);
    start_pass(5);
    wait_done(d0, "t5");
    check_pass("t5");
    check_eq("t5_beat_count", 32'(beats), PAD ? 32'(5 * K) : 32'(3 * K));

`ifdef ZERO_PAD_EN
    // T6: len=3, K=2, data 1,2,3 -> 1,2,2,3,3,0 with the last tap padded.
    mem[0] = 8'd1; mem[1] = 8'd2; mem[2] = 8'd3;
    clear_stats(); d0 = done_cnt;
    exp_q.push_back(beat_t'{8'd1, 1'b1, 1'b0, 1'b0});
    exp_q.push_back(beat_t'{8'd2, 1'b0, 1'b1, 1'b0});
    exp_q.push_back(beat_t'{8'd2, 1'b1, 1'b0, 1'b0});
    exp_q.push_back(beat_t'{8'd3, 1'b0, 1'b1, 1'b0});
    exp_q.push_back(beat_t'{8'd3, 1'b1, 1'b0, 1'b0});
    exp_q.push_back(beat_t'{8'd0, 1'b0, 1'b1, 1'b1});
    start_pass(3);
    wait_done(d0, "t6");
    check_eq("t6_beats", 32'(beats), 6);
    check_eq("t6_rd_cnt", 32'(rd_cnt), 5);
    check_eq("t6_q_empty", 32'(exp_q.size()), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

endmodule
